// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard/branch control and IF/ID outputs of the fetch stage.
//   master : hazard unit / branch resolver / imem side (drives PCwrite,
//            IF_IDwrite, flush, branch_target, instr_in)
//   slave  : fetch_stage (drives pc_out, if_id_pc, if_id_instr,
//            if_id_valid, stalled, stall_count)
interface fetch_stage_if;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  logic             PCwrite;
  logic             IF_IDwrite;
  logic             flush;
  logic [XLEN-1:0]  branch_target;
  logic [XLEN-1:0]  instr_in;
  logic [XLEN-1:0]  pc_out;
  logic [XLEN-1:0]  if_id_pc;
  logic [XLEN-1:0]  if_id_instr;
  logic             if_id_valid;
  logic             stalled;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output PCwrite, IF_IDwrite, flush, branch_target, instr_in,
    input  pc_out, if_id_pc, if_id_instr, if_id_valid, stalled, stall_count
  );

  modport slave (
    input  PCwrite, IF_IDwrite, flush, branch_target, instr_in,
    output pc_out, if_id_pc, if_id_instr, if_id_valid, stalled, stall_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID pipeline register and RUN/STALL tracker.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : fetch_stage_if.slave
//            in : PCwrite, IF_IDwrite, flush, branch_target, instr_in
//            out: pc_out, if_id_pc, if_id_instr, if_id_valid, stalled,
//                 stall_count
// Optional feature: define FETCH_STALL_CNT_EN to build the saturating
// stall-cycle counter; otherwise stall_count is tied to zero.
module fetch_stage (
  input  logic         clk,
  input  logic         reset,
  fetch_stage_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  state_e          state_q,       state_d;
  logic            stalled_q,     stalled_d;
  logic [XLEN-1:0] pc_q,          pc_d;
  logic [XLEN-1:0] if_id_pc_q,    if_id_pc_d;
  logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
  logic            if_id_valid_q, if_id_valid_d;

  // Cycle where PC is frozen and no redirect is pending.
  logic hold_c;
  assign hold_c = !bus.PCwrite && !bus.flush;

  // Next-state for PC, IF/ID and the RUN/STALL tracker.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    // Redirect wins over the hazard enables; target is word-aligned.
    if (bus.flush) begin
      pc_d = {bus.branch_target[XLEN-1:2], 2'b00};
    end else if (bus.PCwrite) begin
      pc_d = pc_q + PC_STEP;
    end

    // Flush squashes IF/ID into a bubble carrying a NOP.
    if (bus.flush) begin
      if_id_pc_d    = '0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (bus.IF_IDwrite) begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = bus.instr_in;
      if_id_valid_d = 1'b1;
    end

    case (state_q)
      RUN:     if (hold_c) state_d = STALL;
      STALL:   if (!hold_c) state_d = RUN;
      default: state_d = RUN;
    endcase

    stalled_d = (state_d == STALL);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      stalled_q     <= 1'b0;
      pc_q          <= '0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stalled_q     <= stalled_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.stalled     = stalled_q;

`ifdef FETCH_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of hold cycles; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.stall_count = '0;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port: PCwrite  input  1  from hazard detection; 1 = PC may advance, 0 = hold PC.
REQ-004 SHALL have port: IF_IDwrite  input  1  from hazard detection; 1 = IF/ID register may load, 0 = hold.
REQ-005 SHALL have port: flush  input  1  branch/jump taken in a later stage; redirect fetch and squash IF/ID.
REQ-006 SHALL have port: branch_target  input  32  redirect address, valid when flush=1.
REQ-007 SHALL have port: instr_in  input  32  instruction read combinationally from instruction memory at pc_out.
REQ-008 SHALL have port: pc_out  output  32  current fetch address, registered, to instruction memory.
REQ-009 SHALL have port: if_id_pc  output  32  PC of the instruction held in IF/ID.
REQ-010 SHALL have port: if_id_instr  output  32  instruction held in IF/ID.
REQ-011 SHALL have port: if_id_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-012 SHALL have port: stalled  output  1  registered; 1 while FSM is in STALL.
REQ-013 SHALL have port: stall_count  output  16  stall-cycle counter (see Configuration).

Function
REQ-014 SHALL update all registers only on the rising edge of clk.
REQ-015 SHALL apply PC priority: reset > flush > PCwrite > hold.
REQ-016 SHALL, on flush=1, load pc_out <= {branch_target[31:2], 2'b00}, regardless of PCwrite.
REQ-017 SHALL, on flush=0 and PCwrite=1, load pc_out <= pc_out + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-018 SHALL, on flush=0 and PCwrite=0, hold pc_out.
REQ-019 SHALL, on flush=1, load IF/ID with if_id_instr=0x00000013 (NOP), if_id_pc=0, if_id_valid=0, regardless of IF_IDwrite.
REQ-020 SHALL, on flush=0 and IF_IDwrite=1, load if_id_pc<=pc_out, if_id_instr<=instr_in, if_id_valid<=1.
REQ-021 SHALL, on flush=0 and IF_IDwrite=0, hold all IF/ID fields unchanged.
REQ-022 SHALL have one-cycle latency: the instruction fetched at pc_out in cycle N appears on if_id_instr in cycle N+1.
REQ-023 SHALL implement a two-state FSM, RUN and STALL; RUN->STALL when PCwrite=0 and flush=0; STALL->RUN when PCwrite=1 or flush=1; otherwise remain.
REQ-024 SHALL drive stalled=1 exactly when the FSM is in STALL.
REQ-025 SHALL NOT corrupt held IF/ID contents across any number of consecutive stall cycles.
REQ-026 SHALL treat PCwrite=1 with IF_IDwrite=0 (or the converse) as independent enables, each governing only its own register.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, set pc_out=0x00000000, if_id_pc=0, if_id_instr=0x00000013, if_id_valid=0, FSM=RUN, stalled=0, stall_count=0.
REQ-028 SHALL let reset override flush, PCwrite and IF_IDwrite in the same cycle, including when asserted mid-stall.
REQ-029 SHALL resume fetching from 0x00000000 on the first edge after reset deasserts, with PCwrite=1.

Configuration
REQ-030 SHALL, with macro FETCH_STALL_CNT_EN defined, increment stall_count by 1 each cycle PCwrite=0 and flush=0, saturating at 0xFFFF and cleared only by reset.
REQ-031 SHALL, without FETCH_STALL_CNT_EN, tie stall_count to constant 0 and infer no counter flops.

Verification
REQ-032 SHALL cover reset then free run: PCwrite=IF_IDwrite=1, instr_in=0x00A00093 -> pc_out 0,4,8; if_id_pc 0 then 4; if_id_valid=1 from cycle 1.
REQ-033 SHALL cover load-use stall: PCwrite=IF_IDwrite=0 for 2 cycles at pc_out=0x10 -> pc_out, if_id_* held, stalled=1 for 2 cycles, stall_count=2 (macro on) / 0 (macro off).
REQ-034 SHALL cover flush during stall: PCwrite=0, flush=1, branch_target=0x00000203 -> pc_out=0x00000200, if_id_instr=0x00000013, if_id_valid=0, stalled=0.
REQ-035 SHALL cover wrap: pc_out=0xFFFFFFFC, PCwrite=1 -> pc_out=0x00000000 next cycle.
REQ-036 SHALL cover reset mid-stall: stalled=1, stall_count=5, reset=1 -> all outputs at REQ-027 values next cycle.
REQ-037 SHALL cover saturation (macro on): 0x10005 consecutive stall cycles -> stall_count=0xFFFF.
